interrupt_controller: RTL and testbench

Prioritised interrupt front-end sitting directly upstream of `Top` (the multi-cycle MIPS core). Captures device interrupt edges and an NMI edge, applies a software-writable mask, and presents one request at a time to the core on `interrupt_r` / `NON_maskable_interrupt` with a source ID. Honours `CPU_busy` hold-off and an ack / end-of-interrupt handshake so the core never sees a request change under it.

---
 rtl/intc_pkg.sv | 12 +
 rtl/intc_if.sv | 31 +++
 rtl/intc_prio_enc.sv | 21 ++
 rtl/interrupt_controller.sv | 87 ++++++++
 tb/tb_interrupt_controller.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/intc_pkg.sv
// Shared types and defaults for the prioritised interrupt front-end.
package intc_pkg;

    localparam int unsigned NUM_IRQ_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/intc_if.sv
// Device/core-facing signal bundle of the interrupt controller.
interface intc_if #(
    parameter int unsigned NUM_IRQ = intc_pkg::NUM_IRQ_DEFAULT
);
    localparam int unsigned ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] irq_in;
    logic               nmi_in;
    logic               mask_wr;
    logic [NUM_IRQ-1:0] mask_data;
    logic               CPU_busy;
    logic               int_ack;
    logic               int_eoi;
    logic               NON_maskable_interrupt;
    logic               interrupt_r;
    logic [ID_W-1:0]    int_id;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] pending;

    // Devices and core side
    modport master (
        output irq_in, nmi_in, mask_wr, mask_data, CPU_busy, int_ack, int_eoi,
        input  NON_maskable_interrupt, interrupt_r, int_id, mask_q, pending
    );

    // Controller side
    modport slave (
        input  irq_in, nmi_in, mask_wr, mask_data, CPU_busy, int_ack, int_eoi,
        output NON_maskable_interrupt, interrupt_r, int_id, mask_q, pending
    );
endinterface

// File: rtl/intc_prio_enc.sv
// Combinational priority encoder: lowest set index wins.
module intc_prio_enc #(
    parameter int unsigned NUM_IRQ = intc_pkg::NUM_IRQ_DEFAULT,
    parameter int unsigned ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [ID_W-1:0]    idx
);
    // Scan downward so the lowest set bit is the last one written
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = ID_W'(i);
            end
        end
    end
endmodule

// File: rtl/interrupt_controller.sv
// Edge-capturing, masked, lowest-index-first interrupt front-end with an
// independent NMI latch and ack / end-of-interrupt handshake.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int unsigned NUM_IRQ = NUM_IRQ_DEFAULT
) (
    input logic   clock,
    input logic   reset,
    intc_if.slave bus
);
    localparam int unsigned ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    state_t             state, state_next;
    logic [NUM_IRQ-1:0] irq_prev, pending_q, pending_next, mask_reg, clr, candidates;
    logic [ID_W-1:0]    id_q, id_next, win_idx;
    logic               win_valid, nmi_prev, nmi_q, req_q;

    assign candidates = pending_q & mask_reg;

    intc_prio_enc #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_prio_enc (
        .req   (candidates),
        .valid (win_valid),
        .idx   (win_idx)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Maskable path; an ack while the NMI latch is set belongs to the NMI
    always_comb begin
        state_next = state;
        id_next    = id_q;
        clr        = '0;
        unique case (state)
            ST_IDLE: begin
                if (win_valid && !bus.CPU_busy) begin
                    state_next = ST_REQ;
                    id_next    = win_idx;
                end
            end
            ST_REQ: begin
                if (bus.int_ack && !nmi_q) begin
                    state_next = ST_SERVICE;
                    clr        = NUM_IRQ'(1) << id_q;
                end
            end
            ST_SERVICE: begin
                if (bus.int_eoi) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A new edge outranks a same-cycle clear of the same bit
    assign pending_next = (pending_q & ~clr) | (bus.irq_in & ~irq_prev);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_prev  <= '0;
            pending_q <= '0;
            mask_reg  <= '0;
            id_q      <= '0;
            req_q     <= 1'b0;
            nmi_prev  <= 1'b0;
            nmi_q     <= 1'b0;
        end else begin
            irq_prev  <= bus.irq_in;
            pending_q <= pending_next;
            if (bus.mask_wr) mask_reg <= bus.mask_data;
            id_q      <= id_next;
            req_q     <= (state_next == ST_REQ);
            nmi_prev  <= bus.nmi_in;
            if (bus.nmi_in && !nmi_prev) nmi_q <= 1'b1;
            else if (bus.int_ack)        nmi_q <= 1'b0;
        end
    end

    assign bus.NON_maskable_interrupt = nmi_q;
    assign bus.interrupt_r            = req_q;
    assign bus.int_id                 = id_q;
    assign bus.mask_q                 = mask_reg;
    assign bus.pending                = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed and randomized bench for interrupt_controller against a
// behavioural model of the edge/mask/priority/handshake rules.
module tb_interrupt_controller;

    localparam int unsigned N = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    intc_if #(.NUM_IRQ(N)) bus ();

    interrupt_controller #(.NUM_IRQ(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Model: pending/mask as plain integers, handshake as two flags
    int unsigned m_pend, m_mask, m_prev_irq, m_id;
    bit          m_prev_nmi, m_nmi, m_presented, m_servicing;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_prev_irq = 0; m_id = 0;
        m_prev_nmi = 0; m_nmi = 0; m_presented = 0; m_servicing = 0;
    endtask

    task automatic model_edge();
        int unsigned irq, rise, cand, clear, low;
        bit nmi_rise;
        irq      = 32'(bus.irq_in);
        rise     = irq & ~m_prev_irq;
        nmi_rise = bus.nmi_in && !m_prev_nmi;
        cand     = m_pend & m_mask;
        clear    = 0;
        if (m_servicing) begin
            if (bus.int_eoi) m_servicing = 0;
        end else if (m_presented) begin
            if (bus.int_ack && !m_nmi) begin
                m_presented = 0;
                m_servicing = 1;
                clear = 32'd1 << m_id;
            end
        end else if (cand != 0 && !bus.CPU_busy) begin
            low = cand & (~cand + 32'd1);
            for (int i = 0; i < int'(N); i++)
                if (low == (32'd1 << i)) m_id = i;
            m_presented = 1;
        end
        m_nmi  = nmi_rise || (m_nmi && !bus.int_ack);
        m_pend = ((m_pend & ~clear) | rise) & 32'hFF;
        if (bus.mask_wr) m_mask = 32'(bus.mask_data);
        m_prev_irq = irq;
        m_prev_nmi = bus.nmi_in;
    endtask

    task automatic compare_all();
        chk("interrupt_r", 32'(bus.interrupt_r), 32'(m_presented));
        chk("nmi", 32'(bus.NON_maskable_interrupt), 32'(m_nmi));
        chk("int_id", 32'(bus.int_id), m_id);
        chk("mask_q", 32'(bus.mask_q), m_mask);
        chk("pending", 32'(bus.pending), m_pend);
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        bus.irq_in = '0; bus.nmi_in = 1'b0; bus.mask_wr = 1'b0; bus.mask_data = '0;
        bus.CPU_busy = 1'b0; bus.int_ack = 1'b0; bus.int_eoi = 1'b0;
    endtask

    task automatic ack_then_eoi();
        bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
        bus.int_eoi = 1'b1; tick(); bus.int_eoi = 1'b0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #12;
        compare_all();
        reset = 1'b0;
        tick();

        // Basic single request, full handshake
        bus.mask_wr = 1'b1; bus.mask_data = 8'hFF; tick(); bus.mask_wr = 1'b0;
        bus.irq_in = 8'h20; tick(); bus.irq_in = '0;
        chk("t1_pending", 32'(bus.pending), 32'h20);
        chk("t1_no_req_yet", 32'(bus.interrupt_r), 32'd0);
        tick();
        chk("t1_req", 32'(bus.interrupt_r), 32'd1);
        chk("t1_id", 32'(bus.int_id), 32'd5);
        bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
        chk("t1_ack_pending", 32'(bus.pending), 32'd0);
        chk("t1_ack_req", 32'(bus.interrupt_r), 32'd0);
        bus.int_eoi = 1'b1; tick(); bus.int_eoi = 1'b0;
        tick();

        // Simultaneous sources: lowest index first
        bus.irq_in = 8'h44; tick(); bus.irq_in = '0;
        tick();
        chk("t2_first_id", 32'(bus.int_id), 32'd2);
        ack_then_eoi();
        tick();
        chk("t2_second_req", 32'(bus.interrupt_r), 32'd1);
        chk("t2_second_id", 32'(bus.int_id), 32'd6);
        ack_then_eoi();

        // Masked source keeps latching; unmasking releases it
        bus.mask_wr = 1'b1; bus.mask_data = 8'h00; tick(); bus.mask_wr = 1'b0;
        bus.irq_in = 8'h08; tick(); bus.irq_in = '0;
        tick(); tick();
        chk("t3_pending", 32'(bus.pending), 32'h08);
        chk("t3_masked", 32'(bus.interrupt_r), 32'd0);
        bus.mask_wr = 1'b1; bus.mask_data = 8'h08; tick(); bus.mask_wr = 1'b0;
        chk("t3_write_cycle", 32'(bus.interrupt_r), 32'd0);
        tick();
        chk("t3_unmasked_req", 32'(bus.interrupt_r), 32'd1);
        chk("t3_id", 32'(bus.int_id), 32'd3);
        ack_then_eoi();

        // CPU_busy holds off issue
        bus.mask_wr = 1'b1; bus.mask_data = 8'hFF; tick(); bus.mask_wr = 1'b0;
        bus.CPU_busy = 1'b1;
        bus.irq_in = 8'h02; tick(); bus.irq_in = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_busy_hold", 32'(bus.interrupt_r), 32'd0);
        end
        bus.CPU_busy = 1'b0; tick();
        chk("t4_release_req", 32'(bus.interrupt_r), 32'd1);
        chk("t4_id", 32'(bus.int_id), 32'd1);
        ack_then_eoi();

        // NMI during SERVICE, shared ack goes to the NMI
        bus.irq_in = 8'h10; tick(); bus.irq_in = '0;
        tick();
        bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
        bus.CPU_busy = 1'b1; bus.nmi_in = 1'b1; tick();
        chk("t5_nmi", 32'(bus.NON_maskable_interrupt), 32'd1);
        bus.nmi_in = 1'b0;
        bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
        chk("t5_nmi_cleared", 32'(bus.NON_maskable_interrupt), 32'd0);
        chk("t5_id_held", 32'(bus.int_id), 32'd4);
        bus.CPU_busy = 1'b0;
        bus.irq_in = 8'h01; tick(); bus.irq_in = '0;
        tick();
        chk("t5_no_nesting", 32'(bus.interrupt_r), 32'd0);
        bus.int_eoi = 1'b1; tick(); bus.int_eoi = 1'b0;
        tick();
        chk("t5_after_eoi_req", 32'(bus.interrupt_r), 32'd1);
        chk("t5_after_eoi_id", 32'(bus.int_id), 32'd0);
        ack_then_eoi();

        // Asynchronous reset while a request is presented
        bus.irq_in = 8'h80; tick(); bus.irq_in = '0;
        tick();
        chk("t6_req_before_reset", 32'(bus.interrupt_r), 32'd1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("t6_rst_req", 32'(bus.interrupt_r), 32'd0);
        chk("t6_rst_id", 32'(bus.int_id), 32'd0);
        chk("t6_rst_pending", 32'(bus.pending), 32'd0);
        chk("t6_rst_mask", 32'(bus.mask_q), 32'd0);
        #3 reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Randomized traffic against the model
        bus.mask_wr = 1'b1; bus.mask_data = 8'hFF; tick();
        for (int c = 0; c < 3000; c++) begin
            bus.irq_in    = N'($urandom & $urandom);
            bus.nmi_in    = ($urandom_range(0, 15) == 0);
            bus.CPU_busy  = ($urandom_range(0, 3) == 0);
            bus.mask_wr   = ($urandom_range(0, 15) == 0);
            bus.mask_data = N'($urandom);
            bus.int_ack   = ($urandom_range(0, 3) == 0) && !(bus.nmi_in && !m_prev_nmi);
            bus.int_eoi   = ($urandom_range(0, 3) == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
